// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Command-side controller for a 16-bit combinational ALU. It takes commands
// over a valid/ready interface and drives the ALU operand and opcode ports from
// registers. After a programmable settle time it captures the ALU result into a
// 32-bit accumulator. It returns the result and error bits over a valid/ready
// response interface. Sticky overflow and divide-by-zero flags are kept until
// the next load or reset.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   cmd_valid      command present
//   cmd_ready      sequencer can accept a command (IDLE only)
//   cmd_load       1 = load cmd_operand into accumulator, 0 = ALU operation
//   cmd_opcode     ALU opcode for ALU operations
//   cmd_operand    B operand, or load value
//   alu_a/b/op     registered drive to the ALU inputs
//   alu_result     ALU result (32 bits)
//   alu_error      ALU error: [0] add/sub overflow, [1] div/mod by zero
//   rsp_valid      response present (RESP state)
//   rsp_ready      consumer accepts response
//   rsp_result     accumulator value after the command
//   rsp_error      error bits of this command
//   acc_out        live accumulator
//   sticky_ovf     overflow seen since last load/reset
//   sticky_dz      div/mod-by-zero seen since last load/reset
//   busy           sequencer is not idle
//
// SETTLE_CYCLES (1..15): number of cycles the ALU inputs are held stable
// before the result is captured.
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_operand,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_error,
  output logic [31:0] acc_out,
  output logic        sticky_ovf,
  output logic        sticky_dz,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 so that the capture happens on
  // the SETTLE_CYCLES-th cycle spent in ISSUE.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_settle_cnt;
  logic [31:0] r_acc;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [3:0]  r_alu_op;
  logic [1:0]  r_rsp_error;
  logic        r_sticky_ovf;
  logic        r_sticky_dz;

  logic        w_cmd_fire;
  logic        w_rsp_fire;
  logic        w_settled;

  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_rsp_fire = rsp_valid & rsp_ready;
  assign w_settled  = (r_state == S_ISSUE) && (r_settle_cnt == 4'd0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of every always_comb guarantees
  // each path assigns the output, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_next_state = cmd_load ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_settled) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_fire) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore, decoded from the state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_ISSUE: begin
      end
      S_RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand registers, settle counter, accumulator, flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle_cnt <= 4'd0;
      r_acc        <= 32'd0;
      r_alu_a      <= 16'd0;
      r_alu_b      <= 16'd0;
      r_alu_op     <= 4'd0;
      r_rsp_error  <= 2'b00;
      r_sticky_ovf <= 1'b0;
      r_sticky_dz  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            if (cmd_load) begin
              r_acc        <= {16'd0, cmd_operand};
              r_rsp_error  <= 2'b00;
              r_sticky_ovf <= 1'b0;
              r_sticky_dz  <= 1'b0;
            end else begin
              // Only the low half of the accumulator feeds operand A.
              r_alu_a      <= r_acc[15:0];
              r_alu_b      <= cmd_operand;
              r_alu_op     <= cmd_opcode;
              r_settle_cnt <= SETTLE_INIT;
            end
          end
        end
        S_ISSUE: begin
          if (r_settle_cnt != 4'd0) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end else begin
            // A divide/mod by zero leaves the accumulator untouched; an
            // overflow still lets the (wrapped) result through.
            if (!alu_error[1]) begin
              r_acc <= alu_result;
            end
            r_rsp_error  <= alu_error;
            r_sticky_ovf <= r_sticky_ovf | alu_error[0];
            r_sticky_dz  <= r_sticky_dz  | alu_error[1];
          end
        end
        S_RESP: begin
          // Everything is held until the response handshake.
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_result = r_acc;
  assign rsp_error  = r_rsp_error;
  assign acc_out    = r_acc;
  assign sticky_ovf = r_sticky_ovf;
  assign sticky_dz  = r_sticky_dz;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Two sequencers (SETTLE_CYCLES = 1 and 4) each drive a behavioural 16-bit ALU.
// Expected accumulator, error and sticky values come from a command-level
// reference model. The first instance gets directed and random traffic with
// random response backpressure. The second checks operand hold and command
// rejection during a long settle.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Instance 0 (SETTLE_CYCLES = 1)
  logic        cmd_valid, cmd_ready, cmd_load;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_operand;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result, acc_out;
  logic [1:0]  rsp_error;
  logic        sticky_ovf, sticky_dz, busy;

  // Instance 1 (SETTLE_CYCLES = 4)
  logic        s4_cmd_valid, s4_cmd_ready, s4_cmd_load;
  logic [3:0]  s4_cmd_opcode;
  logic [15:0] s4_cmd_operand;
  logic [15:0] s4_alu_a, s4_alu_b;
  logic [3:0]  s4_alu_op;
  logic [31:0] s4_alu_result;
  logic [1:0]  s4_alu_error;
  logic        s4_rsp_valid, s4_rsp_ready;
  logic [31:0] s4_rsp_result, s4_acc_out;
  logic [1:0]  s4_rsp_error;
  logic        s4_sticky_ovf, s4_sticky_dz, s4_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (command level)
  logic [31:0] m_acc;
  logic        m_ovf;
  logic        m_dz;

  // Behavioural ALU: returns {error[1:0], result[31:0]}
  function automatic logic [33:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
    logic [31:0] r;
    logic [1:0]  e;
    logic [15:0] s;
    r = 32'd0;
    e = 2'b00;
    s = 16'd0;
    case (op)
      4'd0: begin
        r = {16'd0, a} + {16'd0, b};
        s = a + b;
        e[0] = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'd1: begin
        r = {16'd0, a} - {16'd0, b};
        s = a - b;
        e[0] = (a[15] != b[15]) && (s[15] != a[15]);
      end
      4'd2: r = 32'(a) * 32'(b);
      4'd3: if (b == 16'd0) e[1] = 1'b1; else r = 32'(a / b);
      4'd4: if (b == 16'd0) e[1] = 1'b1; else r = 32'(a % b);
      4'd5:  r = {16'd0, a ^ b};
      4'd6:  r = {16'd0, ~(a ^ b)};
      4'd7:  r = {16'd0, a | b};
      4'd8:  r = {16'd0, ~(a | b)};
      4'd9:  r = {16'd0, a & b};
      4'd10: r = {16'd0, ~(a & b)};
      4'd11: r = {16'd0, ~a};
      4'd14: r = 32'hFFFF_FFFF;
      default: r = 32'd0;
    endcase
    return {e, r};
  endfunction

  assign {alu_error, alu_result}       = alu_fn(alu_a, alu_b, alu_op);
  assign {s4_alu_error, s4_alu_result} = alu_fn(s4_alu_a, s4_alu_b, s4_alu_op);

  alu_sequencer #(.SETTLE_CYCLES(S0)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_opcode  (cmd_opcode),
    .cmd_operand (cmd_operand),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_error   (alu_error),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error),
    .acc_out     (acc_out),
    .sticky_ovf  (sticky_ovf),
    .sticky_dz   (sticky_dz),
    .busy        (busy)
  );

  alu_sequencer #(.SETTLE_CYCLES(S1)) u_dut_s4 (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (s4_cmd_valid),
    .cmd_ready   (s4_cmd_ready),
    .cmd_load    (s4_cmd_load),
    .cmd_opcode  (s4_cmd_opcode),
    .cmd_operand (s4_cmd_operand),
    .alu_a       (s4_alu_a),
    .alu_b       (s4_alu_b),
    .alu_op      (s4_alu_op),
    .alu_result  (s4_alu_result),
    .alu_error   (s4_alu_error),
    .rsp_valid   (s4_rsp_valid),
    .rsp_ready   (s4_rsp_ready),
    .rsp_result  (s4_rsp_result),
    .rsp_error   (s4_rsp_error),
    .acc_out     (s4_acc_out),
    .sticky_ovf  (s4_sticky_ovf),
    .sticky_dz   (s4_sticky_dz),
    .busy        (s4_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command to instance 0 and follow it to completion. The response
  // is held off for 'hold' cycles. Called and returns at a falling edge with
  // the sequencer idle.
  task automatic send(input bit ld, input logic [3:0] op, input logic [15:0] opnd,
                      input int hold);
    int          cyc;
    logic [33:0] ar;
    logic [1:0]  exp_err;
    logic [15:0] a_used;
    check("idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_load    = ld;
    cmd_opcode  = op;
    cmd_operand = opnd;
    rsp_ready   = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    // Noise on the command port while busy must be ignored.
    cmd_valid   = 1'($urandom);
    cmd_load    = 1'($urandom);
    cmd_operand = 16'($urandom);

    a_used = m_acc[15:0];
    if (ld) begin
      m_acc   = {16'd0, opnd};
      exp_err = 2'b00;
      m_ovf   = 1'b0;
      m_dz    = 1'b0;
    end else begin
      ar      = alu_fn(a_used, opnd, op);
      exp_err = ar[33:32];
      if (!exp_err[1]) m_acc = ar[31:0];
      m_ovf = m_ovf | exp_err[0];
      m_dz  = m_dz  | exp_err[1];
      check("issue_alu_a", 32'(alu_a), 32'(a_used));
      check("issue_alu_b", 32'(alu_b), 32'(opnd));
      check("issue_alu_op", 32'(alu_op), 32'(op));
      check("issue_ready", 32'(cmd_ready), 32'd0);
    end
    check("busy", 32'(busy), 32'd1);

    cyc = 1;
    while (!rsp_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), ld ? 32'd1 : 32'(1 + S0));
    check("rsp_result", rsp_result, m_acc);
    check("rsp_error", 32'(rsp_error), 32'(exp_err));
    check("acc_out", acc_out, m_acc);
    check("sticky_ovf", 32'(sticky_ovf), 32'(m_ovf));
    check("sticky_dz", 32'(sticky_dz), 32'(m_dz));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", rsp_result, m_acc);
      check("bp_error", 32'(rsp_error), 32'(exp_err));
      check("bp_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_rsp;
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_load       = 1'b0;
    cmd_opcode     = 4'd0;
    cmd_operand    = 16'd0;
    rsp_ready      = 1'b1;
    s4_cmd_valid   = 1'b0;
    s4_cmd_load    = 1'b0;
    s4_cmd_opcode  = 4'd0;
    s4_cmd_operand = 16'd0;
    s4_rsp_ready   = 1'b1;
    m_acc = 32'd0;
    m_ovf = 1'b0;
    m_dz  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acc", acc_out, 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_sticky", 32'({sticky_ovf, sticky_dz}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Directed scenarios
    send(1'b1, 4'd0, 16'd15, 0);
    send(1'b0, 4'd0, 16'd126, 0);
    check("plan_add", acc_out, 32'd141);
    send(1'b0, 4'd2, 16'd3, 0);
    check("plan_mul", acc_out, 32'h0000_01A7);
    send(1'b0, 4'd3, 16'd0, 0);
    check("plan_div0_acc", acc_out, 32'd423);
    check("plan_div0_dz", 32'(sticky_dz), 32'd1);
    send(1'b1, 4'd0, 16'h7FFF, 0);
    send(1'b0, 4'd0, 16'd1, 0);
    check("plan_ovf_acc", acc_out, 32'h0000_8000);
    check("plan_ovf_flag", 32'(sticky_ovf), 32'd1);
    send(1'b1, 4'd0, 16'd5, 0);
    check("plan_load_clears", 32'({sticky_ovf, sticky_dz}), 32'd0);
    send(1'b0, 4'd1, 16'd9, 4);   // backpressure, 5 - 9 wraps into upper bits
    send(1'b0, 4'd14, 16'd0, 2);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      logic [15:0] opnd;
      case ($urandom % 4)
        0:       opnd = 16'd0;
        1:       opnd = 16'($urandom % 16);
        default: opnd = 16'($urandom);
      endcase
      send(($urandom % 4) == 0, 4'($urandom), opnd, int'($urandom % 3));
    end

    // Reset while in ISSUE abandons the command
    send(1'b1, 4'd0, 16'd7, 0);
    cmd_valid   = 1'b1;
    cmd_load    = 1'b0;
    cmd_opcode  = 4'd0;
    cmd_operand = 16'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_acc = 32'd0;
    m_ovf = 1'b0;
    m_dz  = 1'b0;
    check("mid_rst_acc", acc_out, 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    n_rsp = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check("mid_rst_no_rsp", 32'(n_rsp), 32'd0);

    // Instance 1: long settle, operands held, command port ignored
    s4_cmd_valid   = 1'b1;
    s4_cmd_load    = 1'b1;
    s4_cmd_operand = 16'd100;
    @(posedge clk);
    @(negedge clk);
    s4_cmd_valid = 1'b0;
    check("s4_load_valid", 32'(s4_rsp_valid), 32'd1);
    check("s4_load_result", s4_rsp_result, 32'd100);
    @(negedge clk);
    check("s4_load_done", 32'(s4_cmd_ready), 32'd1);
    s4_cmd_valid   = 1'b1;
    s4_cmd_load    = 1'b0;
    s4_cmd_opcode  = 4'd0;
    s4_cmd_operand = 16'd23;
    @(posedge clk);
    for (int i = 0; i < int'(S1); i++) begin
      @(negedge clk);
      check("s4_hold_a", 32'(s4_alu_a), 32'd100);
      check("s4_hold_b", 32'(s4_alu_b), 32'd23);
      check("s4_hold_op", 32'(s4_alu_op), 32'd0);
      check("s4_hold_valid", 32'(s4_rsp_valid), 32'd0);
      check("s4_hold_ready", 32'(s4_cmd_ready), 32'd0);
      s4_cmd_valid   = 1'b1;
      s4_cmd_load    = 1'($urandom);
      s4_cmd_opcode  = 4'($urandom);
      s4_cmd_operand = 16'($urandom);
    end
    @(negedge clk);
    s4_cmd_valid = 1'b0;
    check("s4_rsp_valid", 32'(s4_rsp_valid), 32'd1);
    check("s4_rsp_result", s4_rsp_result, 32'd123);
    check("s4_rsp_error", 32'(s4_rsp_error), 32'd0);
    check("s4_b_after", 32'(s4_alu_b), 32'd23);
    @(negedge clk);
    check("s4_done_valid", 32'(s4_rsp_valid), 32'd0);
    check("s4_done_ready", 32'(s4_cmd_ready), 32'd1);
    check("s4_acc", s4_acc_out, 32'd123);
    @(negedge clk);
    check("s4_idle", 32'(s4_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
